// File: rtl/alu_issue_queue_if.sv
// Signal bundle between the issue queue, its command source, the ALU and the result sink.
// The slave modport is the queue's view of the bundle; the master modport is the surrounding logic's view.
interface alu_issue_queue_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [1:0]    in_op;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [1:0]    alu_op;
    logic [W-1:0]  alu_y;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic [1:0]    out_op;
    logic          out_zero;
    logic          out_carry;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid, in_a, in_b, in_op, alu_y, out_ready,
        output in_ready, alu_a, alu_b, alu_op,
               out_valid, out_y, out_op, out_zero, out_carry, count
    );

    modport master (
        output in_valid, in_a, in_b, in_op, alu_y, out_ready,
        input  in_ready, alu_a, alu_b, alu_op,
               out_valid, out_y, out_op, out_zero, out_carry, count
    );
endinterface

// File: rtl/alu_issue_queue.sv
// In-order command FIFO feeding a combinational 8-bit ALU, with a registered
// valid/ready result stage that also carries the zero and carry/borrow flags.
module alu_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_queue_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    logic          out_valid_q;
    logic [W-1:0]  out_y_q;
    logic [1:0]    out_op_q;
    logic          out_zero_q;
    logic          out_carry_q;

    entry_t        head;
    logic          has_head;
    logic          in_ready_c;
    logic          push;
    logic          load;
    logic [W:0]    sum9;
    logic          carry_c;

    // Handshakes, ALU drive and the locally computed carry/borrow for the head entry
    always_comb begin
        head       = mem[rd_ptr];
        has_head   = (cnt != CW'(0));
        in_ready_c = !rst && (cnt < CW'(DEPTH));
        push       = bus.in_valid && in_ready_c;
        load       = has_head && (!out_valid_q || bus.out_ready);
        sum9       = {1'b0, head.a} + {1'b0, head.b};
        carry_c    = 1'b0;
        case (head.op)
            OP_ADD:        carry_c = sum9[W];
            OP_SUB:        carry_c = (head.a < head.b);
            OP_AND, OP_OR: carry_c = 1'b0;
            default:       carry_c = 1'b0;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.alu_a     = has_head ? head.a  : W'(0);
    assign bus.alu_b     = has_head ? head.b  : W'(0);
    assign bus.alu_op    = has_head ? head.op : OP_ADD;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_op    = out_op_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_carry = out_carry_q;
    assign bus.count     = cnt;

    // Storage has no reset; occupancy tracking makes stale entries unreachable
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) rd_ptr <= rd_ptr + AW'(1);
            case ({push, load})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Result stage: load on a free or draining slot, otherwise drain or hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_op_q    <= OP_ADD;
            out_zero_q  <= 1'b0;
            out_carry_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_y_q     <= bus.alu_y;
            out_op_q    <= head.op;
            out_zero_q  <= (bus.alu_y == W'(0));
            out_carry_q <= carry_c;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural ALU closing the loop
// between the queue's ALU drive and the ALU result input.
module tb_alu_issue_queue;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [1:0] ADD = 2'd0;
    localparam logic [1:0] SUB = 2'd1;
    localparam logic [1:0] AND = 2'd2;
    localparam logic [1:0] OR  = 2'd3;

    alu_issue_queue_if #(.W(8), .CW(3)) bus ();

    alu_issue_queue #(.DEPTH(4), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational ALU
    always_comb begin
        bus.alu_y = 8'h00;
        case (bus.alu_op)
            ADD: bus.alu_y = bus.alu_a + bus.alu_b;
            SUB: bus.alu_y = bus.alu_a - bus.alu_b;
            AND: bus.alu_y = bus.alu_a & bus.alu_b;
            OR:  bus.alu_y = bus.alu_a | bus.alu_b;
            default: bus.alu_y = 8'h00;
        endcase
    end

    // Stream vectors: ADD a=0x20*i, b=0x70
    logic [7:0] s_a [10] = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0, 8'h00, 8'h20};
    logic [7:0] s_y [10] = '{8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0, 8'h10, 8'h30, 8'h50, 8'h70, 8'h90};
    logic       s_c [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Backpressure vectors and their hand-computed results
    logic [1:0] f_op [6] = '{ADD,   SUB,   AND,   OR,    ADD,   SUB};
    logic [7:0] f_a  [6] = '{8'h10, 8'h30, 8'h3C, 8'h01, 8'h80, 8'h00};
    logic [7:0] f_b  [6] = '{8'h20, 8'h10, 8'h0F, 8'h80, 8'h80, 8'h01};
    logic [7:0] f_y  [6] = '{8'h30, 8'h20, 8'h0C, 8'h81, 8'h00, 8'hFF};
    logic       f_z  [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
    logic       f_c  [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] res_obs();
        return {3'b000, bus.out_valid, bus.out_op, bus.out_y, bus.out_zero, bus.out_carry};
    endfunction

    function automatic logic [15:0] res_exp(input logic v, input logic [1:0] op,
                                            input logic [7:0] y, input logic z, input logic c);
        return {3'b000, v, op, y, z, c};
    endfunction

    task automatic drive(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = ADD;
        bus.in_a      = 8'h00;
        bus.in_b      = 8'h00;
        bus.out_ready = 1'b1;

        // Reset state
        step();
        step();
        check("rst_result", res_obs(), res_exp(1'b0, ADD, 8'h00, 1'b0, 1'b0));
        check("rst_count", 16'(bus.count), 16'd0);
        check("rst_in_ready", 16'(bus.in_ready), 16'd0);
        check("rst_alu_idle", {bus.alu_a, bus.alu_b[5:0], bus.alu_op}, 16'h0000);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 16'(bus.in_ready), 16'd1);

        // Single ADD: one-cycle latency, then drains
        drive(ADD, 8'h7F, 8'h01);
        step();
        bus.in_valid = 1'b0;
        check("t1_not_yet", 16'(bus.out_valid), 16'd0);
        check("t1_count", 16'(bus.count), 16'd1);
        check("t1_alu_drive", {bus.alu_a, bus.alu_b}, 16'h7F01);
        step();
        check("t1_result", res_obs(), res_exp(1'b1, ADD, 8'h80, 1'b0, 1'b0));
        check("t1_count_empty", 16'(bus.count), 16'd0);
        step();
        check("t1_drained", res_obs(), res_exp(1'b0, ADD, 8'h80, 1'b0, 1'b0));

        // ADD with carry-out then SUB with borrow, back to back
        drive(ADD, 8'hFF, 8'h01);
        step();
        drive(SUB, 8'h05, 8'h06);
        step();
        bus.in_valid = 1'b0;
        check("t2_add_carry", res_obs(), res_exp(1'b1, ADD, 8'h00, 1'b1, 1'b1));
        step();
        check("t2_sub_borrow", res_obs(), res_exp(1'b1, SUB, 8'hFF, 1'b0, 1'b1));
        step();
        check("t2_drained", 16'(bus.out_valid), 16'd0);

        // Logic ops never set carry
        drive(AND, 8'hF0, 8'h0F);
        step();
        drive(OR, 8'hA0, 8'h05);
        step();
        bus.in_valid = 1'b0;
        check("t3_and_zero", res_obs(), res_exp(1'b1, AND, 8'h00, 1'b1, 1'b0));
        step();
        check("t3_or", res_obs(), res_exp(1'b1, OR, 8'hA5, 1'b0, 1'b0));
        step();

        // Backpressure: five in flight, sixth waits until the first drain
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(f_op[i], f_a[i], f_b[i]);
            step();
        end
        check("t4_full_count", 16'(bus.count), 16'd4);
        check("t4_full_in_ready", 16'(bus.in_ready), 16'd0);
        check("t4_head_held", res_obs(), res_exp(1'b1, f_op[0], f_y[0], f_z[0], f_c[0]));
        drive(f_op[5], f_a[5], f_b[5]);
        step();
        check("t4_stall_count", 16'(bus.count), 16'd4);
        check("t4_stall_hold", res_obs(), res_exp(1'b1, f_op[0], f_y[0], f_z[0], f_c[0]));
        bus.out_ready = 1'b1;
        step();
        check("t4_res1", res_obs(), res_exp(1'b1, f_op[1], f_y[1], f_z[1], f_c[1]));
        check("t4_count_after_drain", 16'(bus.count), 16'd3);
        check("t4_in_ready_after_drain", 16'(bus.in_ready), 16'd1);
        step();
        bus.in_valid = 1'b0;
        check("t4_res2", res_obs(), res_exp(1'b1, f_op[2], f_y[2], f_z[2], f_c[2]));
        check("t4_count_push_pop", 16'(bus.count), 16'd3);
        for (int i = 3; i < 6; i++) begin
            step();
            check($sformatf("t4_res%0d", i), res_obs(),
                  res_exp(1'b1, f_op[i], f_y[i], f_z[i], f_c[i]));
        end
        step();
        check("t4_drained", 16'(bus.out_valid), 16'd0);
        check("t4_empty", 16'(bus.count), 16'd0);

        // Ten-command stream across pointer wrap, no bubbles
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) drive(ADD, s_a[i], 8'h70);
            else        bus.in_valid = 1'b0;
            step();
            if (i >= 1) begin
                check($sformatf("t5_res%0d", i - 1), res_obs(),
                      res_exp(1'b1, ADD, s_y[i-1], 1'b0, s_c[i-1]));
            end
        end
        step();
        check("t5_drained", 16'(bus.out_valid), 16'd0);

        // Reset mid-stream with three queued and one held
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(ADD, 8'h01, 8'(i));
            step();
        end
        bus.in_valid = 1'b0;
        check("t6_pre_count", 16'(bus.count), 16'd3);
        check("t6_pre_valid", 16'(bus.out_valid), 16'd1);
        rst = 1'b1;
        #1;
        check("t6_in_ready_in_rst", 16'(bus.in_ready), 16'd0);
        step();
        check("t6_rst_result", res_obs(), res_exp(1'b0, ADD, 8'h00, 1'b0, 1'b0));
        check("t6_rst_count", 16'(bus.count), 16'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("t6_in_ready_after", 16'(bus.in_ready), 16'd1);
        step();
        step();
        check("t6_no_stale", 16'(bus.out_valid), 16'd0);
        drive(SUB, 8'h10, 8'h03);
        step();
        bus.in_valid = 1'b0;
        step();
        check("t6_fresh_result", res_obs(), res_exp(1'b1, SUB, 8'h0D, 1'b0, 1'b0));
        step();
        check("t6_fresh_drained", 16'(bus.out_valid), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
Command front-end and result stage for the 8-bit `alu` datapath. Accepts {op, a, b} commands over a valid/ready interface and buffers them in a small in-order FIFO. Drives the FIFO head onto the combinational ALU's a/b/op inputs, then registers the ALU result with zero and carry/borrow flags into a valid/ready output stage. It feeds the ALU and consumes what the ALU produces, so it is both the upstream and downstream neighbour of the ALU.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
W, 8, operand/result width (fixed at 8 to match `alu`; no other value is supported)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  command valid
in_ready  output  1  command accepted when in_valid && in_ready at a clk edge
in_a  input  8  operand a
in_b  input  8  operand b
in_op  input  2  opcode, opcode_e encoding: ADD=0, SUB=1, AND=2, OR=3
alu_a  output  8  to alu.a
alu_b  output  8  to alu.b
alu_op  output  2  to alu.op (opcode_e)
alu_y  input  8  from alu.y
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid && out_ready at a clk edge
out_y  output  8  registered result
out_op  output  2  opcode of out_y
out_zero  output  1  out_y == 0
out_carry  output  1  ADD: bit 8 of a+b; SUB: borrow (a<b unsigned); AND/OR: 0
count  output  3  FIFO occupancy, 0..DEPTH (width clog2(DEPTH)+1)

Behaviour:
- Reset, synchronous, on a clk edge with rst=1:
  - wr_ptr=rd_ptr=count=0, out_valid=0, out_y=0, out_op=ADD, out_zero=0, out_carry=0.
  - FIFO contents are don't-care.
  - in_ready=0 while rst=1.
  - A reset mid-stream discards all queued and held results; nothing already in flight is emitted afterwards.
- in_ready = !rst && (count < DEPTH). There is no bypass when the FIFO is full.
- Push: on in_valid && in_ready, write {in_op,in_a,in_b} at wr_ptr; wr_ptr increments modulo DEPTH.
- ALU drive, combinational:
  - count>0: alu_a/alu_b/alu_op = head entry at rd_ptr.
  - count==0: alu_a=0, alu_b=0, alu_op=ADD.
- Load condition: load = (count>0) && (!out_valid || out_ready).
- On load:
  - pop the head; rd_ptr increments modulo DEPTH.
  - out_y <= alu_y, out_op <= head op, out_zero <= (alu_y==0).
  - out_carry <= the 9-bit sum/borrow computed locally from head a/b per out_carry rule.
  - out_valid <= 1.
- Drain without refill: out_valid && out_ready && count==0 -> out_valid <= 0; out_y and flags hold their last values.
- Stall: out_valid && !out_ready -> out_y/out_op/flags/out_valid hold and no pop occurs.
- count update:
  - push and pop in the same cycle -> count unchanged.
  - push only -> count+1.
  - pop only -> count-1.
- Latency: a command accepted at edge E0 with an empty FIFO and an idle output appears as out_valid=1 after edge E1.
- Throughput: one command per cycle sustained while out_ready=1.
- Ordering: results come out strictly in acceptance order.
- Capacity: DEPTH+1 commands in flight (FIFO plus output register) before in_ready drops.
- Wrap-around: pointer wrap from DEPTH-1 to 0 is transparent; full and empty are distinguished by count.
- Arithmetic wraps modulo 256 (ALU behaviour); the carry/borrow flag is the only overflow indication.

Test Plan:
1. Reset, then push ADD a=0x7F b=0x01 with out_ready=1 -> out_valid=1 exactly one cycle after accept; out_y=0x80, out_zero=0, out_carry=0, out_op=ADD; out_valid=0 on the following cycle.
2. ADD 0xFF+0x01 then SUB 0x05-0x06 back-to-back -> out_y=0x00 (zero=1, carry=1), then out_y=0xFF (zero=0, carry=1, borrow), on consecutive cycles.
3. AND 0xF0&0x0F then OR 0xA0|0x05 -> out_y=0x00 (zero=1, carry=0), then out_y=0xA5 (zero=0, carry=0).
4. out_ready=0, push 6 commands continuously -> 5 accepted (count reaches 4, first result held in output register) and in_ready=0 on the 6th. Then out_ready=1 -> 5 results in order, one per cycle, with in_ready=1 after the first drain; the 6th command, held valid throughout, is then accepted and emitted in order.
5. Stream 10 commands with out_ready=1 -> pointers wrap; all 10 results are correct, in order, one per cycle, with no bubbles after the first.
6. With count=3 and out_valid=1, assert rst for 1 cycle -> count=0, out_valid=0, out_y=0, in_ready=0 during reset and 1 after. No stale result appears; the next command gives a correct result one cycle after accept.
